// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared repeat-state type and counter sizing helpers for the button front end
package btn_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_chan.sv
// btn_event_chan: one button channel - synchroniser, debounce, edge pulses and hold-to-repeat
module btn_event_chan
    import btn_event_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    input  logic rpt_en,
    output logic level,
    output logic press,
    output logic rel,
    output logic held
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DW-1:0] D_TOP = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_TOP = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_TOP = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt, rcnt_d;
    logic lvl, s, fire, rise, fall, tick;
    rpt_state_t state, state_d;

    assign s     = sync[SYNC_STAGES-1];
    assign fire  = (s != lvl) && (dcnt == D_TOP);
    assign rise  = fire && s;
    assign fall  = fire && !s;
    assign level = lvl;
    assign held  = (state == REPEAT);

    // synchronise the pin, debounce it, and register the press/release pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            dcnt  <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], in};
            dcnt  <= (s == lvl || fire) ? '0 : dcnt + 1'b1;
            lvl   <= fire ? s : lvl;
            press <= rise || tick;
            rel   <= fall;
        end
    end

    // repeat state and its cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
        end
    end

    // repeat sequencing; a release or disable wins over a coincident tick
    always_comb begin
        state_d = state;
        rcnt_d  = rcnt;
        tick    = 1'b0;
        case (state)
            IDLE: begin
                if (rise && rpt_en) begin
                    state_d = DELAY;
                    rcnt_d  = '0;
                end
            end
            DELAY: begin
                if (fall || !rpt_en) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt == RD_TOP) begin
                    state_d = REPEAT;
                    rcnt_d  = '0;
                    tick    = 1'b1;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (fall || !rpt_en) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt == RP_TOP) begin
                    rcnt_d = '0;
                    tick   = 1'b1;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: array of independent debounced button channels with press/release/repeat events
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] rpt_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        btn_event_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (in[i]),
            .rpt_en(rpt_en[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .held  (held[i])
        );
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: vector table, reset corner cases and random stimulus against an event-level model
module tb_btn_event_gen;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [CH-1:0] in = '0;
    logic [CH-1:0] rpt_en = '0;
    logic [CH-1:0] level, press, rel, held;
    logic [4*CH-1:0] outs;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit sh[CH][SS];
    int run[CH];
    bit mlvl[CH];
    bit act[CH];
    int age[CH];
    bit mp[CH];
    bit mr[CH];
    int hold_left[CH];

    typedef struct {
        logic [CH-1:0] in;
        logic [CH-1:0] rpt;
        int            n;
        logic [CH-1:0] lv;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] hd;
    } vec_t;

    vec_t tbl[$];

    btn_event_gen #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .rpt_en(rpt_en),
        .level (level),
        .press (press),
        .rel   (rel),
        .held  (held)
    );

    always #5 clk = ~clk;

    assign outs = {level, press, rel, held};

    task automatic cmp(input string name, input logic [4*CH-1:0] act_v, input logic [4*CH-1:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d got {lvl,prs,rel,hld}=%b expected %b", name, cyc, act_v, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            for (int j = 0; j < SS; j++) sh[i][j] = 1'b0;
            run[i] = 0;
            mlvl[i] = 1'b0;
            act[i] = 1'b0;
            age[i] = 0;
            mp[i] = 1'b0;
            mr[i] = 1'b0;
        end
    endfunction

    // a level change is accepted once the synchronised pin has disagreed for DC edges in a row;
    // repeat ticks fall at ages RD, RD+RP, RD+2RP, ... edges after an enabled press
    function automatic void model_edge();
        for (int i = 0; i < CH; i++) begin
            bit s, rise, fall, tick;
            s = sh[i][SS-1];
            rise = 1'b0;
            fall = 1'b0;
            tick = 1'b0;
            if (s != mlvl[i]) begin
                run[i]++;
                if (run[i] == DC) begin
                    mlvl[i] = s;
                    run[i] = 0;
                    rise = s;
                    fall = !s;
                end
            end else begin
                run[i] = 0;
            end
            if (rise && rpt_en[i]) begin
                act[i] = 1'b1;
                age[i] = 0;
            end else if (act[i]) begin
                if (fall || !rpt_en[i]) begin
                    act[i] = 1'b0;
                end else begin
                    age[i]++;
                    tick = (age[i] >= RD) && ((age[i] - RD) % RP == 0);
                end
            end
            mp[i] = rise || tick;
            mr[i] = fall;
            for (int j = SS - 1; j > 0; j--) sh[i][j] = sh[i][j-1];
            sh[i][0] = in[i];
        end
    endfunction

    function automatic logic [4*CH-1:0] model_out();
        logic [CH-1:0] lv, pr, rl, hd;
        for (int i = 0; i < CH; i++) begin
            lv[i] = mlvl[i];
            pr[i] = mp[i];
            rl[i] = mr[i];
            hd[i] = act[i] && (age[i] >= RD);
        end
        return {lv, pr, rl, hd};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        cmp("model", outs, model_out());
    endtask

    // assert reset between edges, check the outputs clear with no clock, release on the next negedge
    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1 cmp(name, outs, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl.push_back(vec_t'{2'b11, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b11, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 7, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b01, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b01, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b01, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b01, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b00, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b00, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b00, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b01, 4, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 6, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 4, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b00, 10, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b01, 2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00});

        in = 2'b11;
        #2 rst_n = 1'b0;
        #1 cmp("reset_async", outs, '0);
        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset_hold", outs, '0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            in = tbl[k].in;
            rpt_en = tbl[k].rpt;
            repeat (tbl[k].n) step();
            cmp($sformatf("vec%0d", k), outs, {tbl[k].lv, tbl[k].pr, tbl[k].rl, tbl[k].hd});
        end

        in = 2'b01;
        rpt_en = 2'b01;
        repeat (16) step();
        cmp("pre_reset_held", {4'b0, held[0], 3'b0}, 8'b0000_1000);
        do_reset("reset_mid_repeat");
        repeat (5) step();
        cmp("post_reset_quiet", {6'b0, level[0], press[0]}, 8'b0000_0000);
        step();
        cmp("post_reset_press", {6'b0, level[0], press[0]}, 8'b0000_0011);
        repeat (7) step();
        step();
        cmp("post_reset_repeat", {6'b0, press[0], held[0]}, 8'b0000_0011);

        in = '0;
        rpt_en = '0;
        for (int i = 0; i < CH; i++) hold_left[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < CH; i++) begin
                if (hold_left[i] == 0) begin
                    in[i] = $urandom_range(0, 1) == 1;
                    hold_left[i] = $urandom_range(1, 14);
                end
                hold_left[i]--;
                if ($urandom_range(0, 39) == 0) rpt_en[i] = ~rpt_en[i];
            end
            if ($urandom_range(0, 499) == 0) do_reset("reset_random");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_event_gen.md
# btn_event_gen

Multi-channel button front end for the alarm-clock user inputs. It replaces per-button single-edge detection with one parametrised block. Each channel synchronises a raw push-button input, debounces it, and emits one-cycle press/release pulses. Each channel also has optional hold-to-auto-repeat press pulses, used for fast time/alarm setting. It sits between the board pins and the clock/alarm control FSMs.

## Interface
- CHANNELS, 5: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles of disagreement required to change the debounced level (≥1; 10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles from debounced press to first repeat pulse (≥1).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat pulses (≥1).
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in  input  CHANNELS  raw asynchronous button levels; 1 = pressed.
- rpt_en  input  CHANNELS  per-channel auto-repeat enable; sampled synchronously.
- level  output  CHANNELS  debounced button state.
- press  output  CHANNELS  one-cycle pulse on each debounced press and on each auto-repeat tick.
- release  output  CHANNELS  one-cycle pulse on each debounced release.
- held  output  CHANNELS  high while the channel is in the auto-repeat phase.

## Operation
Channels are fully independent and identical. Per channel:
- **Synchroniser.** `in` passes through SYNC_STAGES flops. The last stage is `s`.
- **Debounce.** Register `lvl` drives `level`. Counter `dcnt` has width $clog2(DEBOUNCE_CYCLES) (minimum 1).
  - If `s == lvl`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `lvl <= s` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - A disagreement shorter than DEBOUNCE_CYCLES cycles leaves `lvl` unchanged and restarts the count.
- **Edge pulses.** `press` and `release` are registered outputs.
  - `press` is high in the single cycle in which `lvl` first reads 1, i.e. coincident with the rising edge of `level`.
  - `release` is high in the single cycle in which `lvl` first reads 0.
- **Repeat FSM.** States are IDLE, DELAY and REPEAT. Counter `rcnt` has width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - IDLE: on `lvl` 0→1 with `rpt_en` = 1, go to DELAY with `rcnt <= 0`. The normal press pulse still fires.
  - DELAY: `rcnt` increments each cycle. At `rcnt == REPEAT_DELAY-1`: go to REPEAT, pulse `press`, set `rcnt <= 0`.
  - REPEAT: `rcnt` increments each cycle. At `rcnt == REPEAT_PERIOD-1`: pulse `press` and set `rcnt <= 0`.
  - From DELAY or REPEAT: `lvl` 1→0 goes to IDLE. `rpt_en` = 0 also goes to IDLE. No repeat pulse fires in that cycle. Release-to-IDLE takes priority over a coincident repeat tick.
  - While in REPEAT, `held` = 1. Otherwise `held` = 0.
  - Enabling `rpt_en` while the button is already held does not start repeating. Repeating starts only at the next debounced press.

## Timing
- Reset values: all synchroniser flops, `lvl`, `dcnt`, `rcnt`, `level`, `press`, `release` and `held` are 0; the FSM is in IDLE.
  - All outputs clear immediately on `rst_n` falling, with no clock required.
- Latency: a clean input change is seen on `level`, `press` or `release` exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the edge that first samples it.
- First repeat pulse: REPEAT_DELAY cycles after the debounced press pulse. Subsequent pulses: every REPEAT_PERIOD cycles.
- `press` and `release` are never high in the same cycle on one channel. Each pulse lasts exactly one cycle.
- Reset mid-operation: all state clears. If `in` is still 1 after `rst_n` rises, a fresh press is detected after the full latency.
- Counters never wrap. Each is cleared at its terminal value.

## Structure
- Package `btn_event_pkg`:
  - Repeat-state enum: IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2.
  - Width helper function for counter sizing.
- Sub-module `btn_event_chan`: one channel holding the synchroniser, debounce, edge and repeat logic.
  - `btn_event_gen` instantiates CHANNELS copies in a generate loop.
  - The top level has no other logic.

## Test plan
Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3. Edge numbering counts from the first edge that samples the change.
1. Reset: hold `rst_n` = 0 with `in` = 2'b11 → all outputs 0. Release reset → `level` = 2'b11 at edge 6, with one `press` pulse per channel.
2. Clean press/release on ch0, `rpt_en` = 0:
   - Rise → `level[0]` and a single-cycle `press[0]` at edge 6.
   - Fall → a single-cycle `release[0]` 6 edges later.
   - Ch1 outputs stay 0 throughout.
3. Bounce: ch0 high glitches of 1, 2 and 3 cycles separated by 1 low cycle → `level[0]` stays 0; no `press` or `release`.
4. Auto-repeat: `rpt_en[0]` = 1, hold `in[0]` for 30 cycles → `press[0]` at edges 6, 14, 17, 20, 23, …; `held[0]` = 1 from edge 14.
5. Abort repeat, two cases:
   - Drop `in[0]` during REPEAT → `release[0]` after 6 edges; `held[0]` falls with it; no further press pulses.
   - Drop `rpt_en[0]` in DELAY → no repeat pulses; `level[0]` stays 1.
6. Asynchronous reset mid-repeat:
   - Assert `rst_n` low between clock edges → all outputs 0 before the next edge.
   - Deassert with `in[0]` still 1 → a new `press[0]` at edge 6, followed by repeats.
